cas_sig_dec: RTL
================

CAS_SIG_DEC -- requirements
Module: cas_sig_dec

Interface
REQ-001 Parameter THRESH, default 5442: low-phase length in clk cycles; a low phase of this length or more decodes as bit 0, shorter decodes as bit 1.
REQ-002 Parameter MIN_LOW, default 1000: low phases shorter than this many cycles are glitches.
REQ-003 Parameter TIMEOUT, default 20000: maximum low-phase or high-phase length in cycles before carrier is lost.
REQ-004 Parameter SYNC_BITS, default 16: consecutive 1 bits in HUNT needed to assert carrier.
REQ-005 clk  input  1  system clock, 24 MHz nominal; one clock; all logic on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 en  input  1  decoder enable; when low, decoder is held idle.
REQ-008 din  input  1  raw tape level, asynchronous to clk.
REQ-009 dout  output  8  last received byte.
REQ-010 valid  output  1  one-cycle pulse; dout and parity_err are updated in the same cycle.
REQ-011 parity_err  output  1  parity status of the byte in dout.
REQ-012 frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-013 carrier  output  1  level; high while a sync tone or frames are being tracked.

Function
REQ-014 din SHALL pass through a 2-flop synchronizer; edges are detected on the synchronized signal (falling = 1->0, rising = 0->1).
REQ-015 A 16-bit phase counter SHALL clear on every synchronized edge and increment otherwise, saturating at 0xFFFF.
REQ-016 On a rising edge, the low-phase length L SHALL be the counter value before clearing. L < MIN_LOW: discard, no state change. L >= THRESH: bit 0. Otherwise: bit 1.
REQ-017 Each bit decision SHALL be registered one cycle after the synchronized rising edge ("bit cycle").
REQ-018 Counter > TIMEOUT in either phase SHALL force state HUNT, carrier=0, sync count=0 and bit index=0. No valid or frame_err is emitted.
REQ-019 States: HUNT, DATA, PARITY, STOP.
REQ-020 HUNT, bit 1: sync count increments, saturating at 255; carrier=1 once the count reaches SYNC_BITS.
REQ-021 HUNT, bit 0: if carrier=1 this is the start bit -> DATA with bit index=0 and parity accumulator=1; if carrier=0 the sync count clears and state stays HUNT.
REQ-022 DATA: each bit shifts into the shift register LSB-first (bit in at MSB, shift right); accumulator ^= bit; after the 8th bit -> PARITY.
REQ-023 PARITY: expected parity bit = accumulator, i.e. 1 XOR (XOR of the 8 data bits); mismatch latches an internal perr flag; -> STOP.
REQ-024 STOP, bit 1: valid=1 for one cycle, dout=shift register, parity_err=perr -> HUNT with carrier kept at 1 and sync count=SYNC_BITS.
REQ-025 STOP, bit 0: frame_err=1 for one cycle; dout and parity_err unchanged; -> HUNT, carrier=0, sync count=0.
REQ-026 The trailing stop bits after the first are consumed in HUNT as sync 1 bits.
REQ-027 Latency: valid SHALL assert on the bit cycle of the first stop bit.
REQ-028 en=0: state HUNT, counters and flags cleared, carrier=0, valid and frame_err held 0; dout and parity_err are retained.
REQ-029 en falling mid-frame SHALL abort the frame without any output pulse.
REQ-030 A rising edge and a timeout in the same cycle: the timeout wins and the bit is discarded.

Reset
REQ-031 reset_n low SHALL asynchronously set dout=0x00, valid=0, parity_err=0, frame_err=0, carrier=0, state=HUNT, all counters and synchronizer flops to 0.
REQ-032 After reset_n deasserts, the first edge SHALL be detected only after the synchronizer has been filled from din; no spurious bit is produced from the reset value.

Verification
REQ-033 20 bits of 1 (4354 low / 4354 high), then byte 0xA5 with correct parity and 4 stop bits -> carrier=1 after the 16th bit; valid pulses once with dout=0xA5, parity_err=0.
REQ-034 Same sequence but the parity bit is inverted -> valid pulses with dout=0xA5, parity_err=1.
REQ-035 Sync tone, then byte 0x3C whose first stop bit is 0 (6530 low / 8709 high) -> frame_err pulses, no valid, carrier=0, dout unchanged.
REQ-036 Sync tone, then a 500-cycle low glitch inside a high phase, then a valid 0x00 frame -> glitch ignored, valid with dout=0x00 and parity_err=0.
REQ-037 Sync tone, start bit and 4 data bits, then din held high 25000 cycles -> carrier drops at counter 20001, no valid; a fresh sync tone plus 0xFF then decodes correctly.
REQ-038 reset_n pulsed low mid-frame and en deasserted mid-frame, each tested separately -> outputs match REQ-031 / REQ-028; the next full sync tone plus byte decodes correctly.

Source files
------------

// File: rtl/cas_sig_dec.sv
`default_nettype none
// ============================================================================
// Module   : cas_sig_dec
// Brief    : Cassette tape signal decoder. Measures low-phase lengths of the
//            synchronized tape level, classifies them as 0/1 bits, tracks a
//            sync tone for carrier detect and frames start/8 data/odd
//            parity/stop bytes.
// Revision : 1.0 - initial release
// ============================================================================
module cas_sig_dec #(
    parameter int THRESH    = 5442,
    parameter int MIN_LOW   = 1000,
    parameter int TIMEOUT   = 20000,
    parameter int SYNC_BITS = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic       din,
    output logic [7:0] dout,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       carrier
);

    localparam logic [1:0]  ST_HUNT   = 2'd0;
    localparam logic [1:0]  ST_DATA   = 2'd1;
    localparam logic [1:0]  ST_PARITY = 2'd2;
    localparam logic [1:0]  ST_STOP   = 2'd3;

    localparam logic [15:0] C_THRESH  = 16'(THRESH);
    localparam logic [15:0] C_MIN_LOW = 16'(MIN_LOW);
    localparam logic [15:0] C_TIMEOUT = 16'(TIMEOUT);
    localparam logic [7:0]  C_SYNC    = 8'(SYNC_BITS);

    // Synchronizer chain, fill tracker and phase counter
    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        prev_q, prev_d;
    logic [1:0]  fill_q, fill_d;
    logic [15:0] cnt_q, cnt_d;

    // Framing state
    logic [1:0]  state_q, state_d;
    logic [7:0]  sync_cnt_q, sync_cnt_d;
    logic        carrier_q, carrier_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        acc_q, acc_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        perr_q, perr_d;

    // Output registers
    logic [7:0]  dout_q, dout_d;
    logic        valid_q, valid_d;
    logic        parity_err_q, parity_err_d;
    logic        frame_err_q, frame_err_d;

    // Edges are only trusted once all three flops hold real din samples, so
    // the reset value of the chain can never masquerade as an edge.
    logic w_edge;
    logic w_rise;
    logic w_timeout;
    logic w_bit_ok;
    logic w_bit;

    assign w_edge    = (fill_q == 2'd3) && (sync2_q != prev_q);
    assign w_rise    = w_edge && sync2_q;
    assign w_timeout = en && (cnt_q > C_TIMEOUT);
    // Timeout has priority over a coincident rising edge.
    assign w_bit_ok  = en && w_rise && !w_timeout && (cnt_q >= C_MIN_LOW);
    assign w_bit     = (cnt_q < C_THRESH);

    // Synchronizer, fill tracking and saturating phase counter
    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        fill_d  = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
        if (!en || w_edge) begin
            cnt_d = 16'd0;
        end else if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Bit framing: sync hunt, data shift, parity check and stop decision
    always_comb begin
        state_d      = state_q;
        sync_cnt_d   = sync_cnt_q;
        carrier_d    = carrier_q;
        bit_idx_d    = bit_idx_q;
        acc_d        = acc_q;
        shreg_d      = shreg_q;
        perr_d       = perr_q;
        dout_d       = dout_q;
        parity_err_d = parity_err_q;
        valid_d      = 1'b0;
        frame_err_d  = 1'b0;

        if (!en) begin
            state_d    = ST_HUNT;
            sync_cnt_d = 8'd0;
            carrier_d  = 1'b0;
            bit_idx_d  = 3'd0;
            acc_d      = 1'b0;
            shreg_d    = 8'd0;
            perr_d     = 1'b0;
        end else if (w_timeout) begin
            state_d    = ST_HUNT;
            sync_cnt_d = 8'd0;
            carrier_d  = 1'b0;
            bit_idx_d  = 3'd0;
        end else if (w_bit_ok) begin
            case (state_q)
                ST_HUNT: begin
                    if (w_bit) begin
                        if (sync_cnt_q != 8'hFF) begin
                            sync_cnt_d = sync_cnt_q + 8'd1;
                        end
                        if (sync_cnt_d >= C_SYNC) begin
                            carrier_d = 1'b1;
                        end
                    end else if (carrier_q) begin
                        // Start bit: odd parity seeds the accumulator with 1
                        state_d   = ST_DATA;
                        bit_idx_d = 3'd0;
                        acc_d     = 1'b1;
                        perr_d    = 1'b0;
                    end else begin
                        sync_cnt_d = 8'd0;
                    end
                end
                ST_DATA: begin
                    shreg_d   = {w_bit, shreg_q[7:1]};
                    acc_d     = acc_q ^ w_bit;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    if (w_bit != acc_q) begin
                        perr_d = 1'b1;
                    end
                    state_d = ST_STOP;
                end
                default: begin
                    state_d = ST_HUNT;
                    if (w_bit) begin
                        valid_d      = 1'b1;
                        dout_d       = shreg_q;
                        parity_err_d = perr_q;
                        carrier_d    = 1'b1;
                        sync_cnt_d   = C_SYNC;
                    end else begin
                        frame_err_d = 1'b1;
                        carrier_d   = 1'b0;
                        sync_cnt_d  = 8'd0;
                    end
                end
            endcase
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            prev_q       <= 1'b0;
            fill_q       <= 2'd0;
            cnt_q        <= 16'd0;
            state_q      <= ST_HUNT;
            sync_cnt_q   <= 8'd0;
            carrier_q    <= 1'b0;
            bit_idx_q    <= 3'd0;
            acc_q        <= 1'b0;
            shreg_q      <= 8'd0;
            perr_q       <= 1'b0;
            dout_q       <= 8'd0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            fill_q       <= fill_d;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            sync_cnt_q   <= sync_cnt_d;
            carrier_q    <= carrier_d;
            bit_idx_q    <= bit_idx_d;
            acc_q        <= acc_d;
            shreg_q      <= shreg_d;
            perr_q       <= perr_d;
            dout_q       <= dout_d;
            valid_q      <= valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign dout       = dout_q;
    assign valid      = valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign carrier    = carrier_q;

endmodule
`default_nettype wire
